// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_if
//  Description : Handshake bundle between the execute stage and the
//                iterative RV32M divider.
//                  in_valid/in_ready/op/a/b : operation request
//                  flush                    : abandon the operation in flight
//                  out_valid/out_ready/out  : registered result
//                  busy                     : stall hint for the hazard unit
//                master = execute/writeback side, slave = div_unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            busy;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//                One quotient bit per cycle, MSB first, 32 iterations.
//                Divide-by-zero and signed overflow produce the architectural
//                RISC-V results without traps.
//  Ports       : clk, rst_n (async, active-low)
//                bus (div_unit_if.slave):
//                  in_valid/in_ready, op[1:0], a, b  - request (op = funct3[1:0])
//                  flush                             - drop current operation
//                  out_valid/out_ready, out          - held result
//                  busy                              - high in CALC or DONE
//  Config      : DIV_EARLY_OUT_EN - when defined, divide-by-zero and signed
//                overflow are resolved at capture and skip CALC entirely.
//                Result values are identical in both builds.
//  Revision    : 1.0  initial release
// ============================================================================
module div_unit #(
  parameter int XLEN = 32   // only 32 is supported; iteration count = XLEN
) (
  input  logic        clk,
  input  logic        rst_n,
  div_unit_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      state_q,   state_d;
  logic [5:0]      cnt_q,     cnt_d;
  logic [XLEN-1:0] dvd_q,     dvd_d;     // dividend, becomes quotient
  logic [XLEN-1:0] dsr_q,     dsr_d;     // divisor magnitude
  logic [XLEN-1:0] rem_q,     rem_d;     // partial remainder
  logic [XLEN-1:0] out_q,     out_d;
  logic            neg_quo_q, neg_quo_d; // quotient must be negated
  logic            neg_rem_q, neg_rem_d; // remainder must be negated
  logic            sel_rem_q, sel_rem_d; // op[1]: return remainder
  logic            dz_q,      dz_d;      // divisor was zero

  // --------------------------------------------------------------------------
  // Capture-side decode (only meaningful while in IDLE)
  // --------------------------------------------------------------------------
  logic            in_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            sgn_ovf;
  logic            special;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] special_res;

  // op[0] clear selects the signed variants (DIV = 00, REM = 10).
  assign in_signed = ~bus.op[0];
  assign a_neg     = in_signed & bus.a[XLEN-1];
  assign b_neg     = in_signed & bus.b[XLEN-1];
  assign a_abs     = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_abs     = b_neg ? (~bus.b + 1'b1) : bus.b;
  assign b_zero    = (bus.b == '0);
  assign sgn_ovf   = in_signed & (bus.a == INT_MIN) & (bus.b == ALL_ONES);
  assign special   = b_zero | sgn_ovf;

  // Architectural results for the two corner cases, used by the early-out
  // path. Divide-by-zero returns all ones / the dividend; overflow returns
  // INT_MIN / zero.
  always_comb begin
    special_res = '0;
    if (b_zero) begin
      special_res = bus.op[1] ? bus.a : ALL_ONES;
    end else begin
      special_res = bus.op[1] ? '0 : INT_MIN;
    end
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  logic [XLEN:0]   trial_sh;
  logic [XLEN:0]   trial_diff;
  logic            trial_neg;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Bring the next dividend bit into the remainder and trial-subtract.
  assign trial_sh   = {rem_q, dvd_q[XLEN-1]};
  assign trial_diff = trial_sh - {1'b0, dsr_q};
  assign trial_neg  = trial_diff[XLEN];

  // The remainder is always below the divisor, so the low XLEN bits of
  // either candidate carry the whole value.
  assign rem_next = trial_neg ? trial_sh[XLEN-1:0] : trial_diff[XLEN-1:0];
  assign quo_next = {dvd_q[XLEN-2:0], ~trial_neg};

  // Sign fix-up of the last iteration's values. Signed overflow needs no
  // override: |INT_MIN| / 1 is INT_MIN with both signs negative, so no
  // negation applies and the remainder is zero. Divide-by-zero leaves |a| in
  // the remainder, which the dividend-sign negation turns back into a; only
  // the quotient must be forced to all ones.
  assign quo_fix = dz_q      ? ALL_ONES
                 : neg_quo_q ? (~quo_next + 1'b1)
                 :             quo_next;
  assign rem_fix = neg_rem_q ? (~rem_next + 1'b1) : rem_next;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    out_d     = out_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    dz_d      = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && !bus.flush) begin
          dvd_d     = a_abs;
          dsr_d     = b_abs;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          sel_rem_d = bus.op[1];
          dz_d      = b_zero;
          state_d   = S_CALC;
          if (EARLY_OUT && special) begin
            out_d   = special_res;
            state_d = S_DONE;
          end
        end
      end

      S_CALC: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          out_d   = sel_rem_q ? rem_fix : quo_fix;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A redirect discards whatever is in flight, including a request that
    // arrives in the same cycle.
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      dz_q      <= dz_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: decoded from state or straight from flops
  // --------------------------------------------------------------------------
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. A vector table drives the
//                main arithmetic cases; hand-written sequences cover
//                back-pressure, flush and asynchronous reset. Expected results
//                are queued at drive time and popped when the result retires.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_unit;

  localparam int XLEN      = 32;
  localparam int LAT_CALC  = 33;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic rst_n;

  div_unit_if #(.XLEN(XLEN)) bus ();

  div_unit #(.XLEN(XLEN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          special;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input bit special);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.special = special;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Drive/sample phase: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check_bit({name, "/ready_timeout"}, bus.in_ready, 1'b1);
  endtask

  // Returns edges after the handshake edge, in the same T+k numbering.
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check({name, "/no_valid"}, 32'(seen), 32'd0);
  endtask

  // Scoreboard: a result retires on a rising edge with out_valid && out_ready;
  // look at it half a cycle before that edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb/unexpected_result", bus.out, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb/out", bus.out, e);
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res,
                        input int lat_exp, input string name);
    int lat;
    wait_ready(name);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    exp_q.push_back(res);
    tick();                          // handshake edge T
    bus.in_valid = 1'b0;
    bus.op = 2'($urandom_range(0, 3));
    bus.a  = $urandom;
    bus.b  = $urandom;
    check_bit({name, "/in_ready_low"}, bus.in_ready, 1'b0);
    wait_valid(lat);
    check({name, "/latency"}, 32'(lat), 32'(lat_exp));
    tick();                          // retire edge (out_ready high)
    check_bit({name, "/in_ready_back"}, bus.in_ready, 1'b1);
    check_bit({name, "/valid_drop"}, bus.out_valid, 1'b0);
  endtask

  initial begin : main
    int lat;

    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    add(OP_DIVU, 32'd100,      32'd7,          32'd14,         1'b0);
    add(OP_REMU, 32'd100,      32'd7,          32'd2,          1'b0);
    add(OP_DIV,  32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   1'b0);
    add(OP_REM,  32'hFFFFFF9C, 32'd7,          32'hFFFFFFFE,   1'b0);
    add(OP_DIV,  32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0);
    add(OP_REM,  32'd100,      32'hFFFFFFF9,   32'd2,          1'b0);
    add(OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         1'b0);
    add(OP_REM,  32'hFFFFFF9C, 32'hFFFFFFF9,   32'hFFFFFFFE,   1'b0);
    add(OP_DIV,  32'd5,        32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REM,  32'd5,        32'd0,          32'd5,          1'b1);
    add(OP_DIV,  32'hFFFFFFFB, 32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REM,  32'hFFFFFFFB, 32'd0,          32'hFFFFFFFB,   1'b1);
    add(OP_DIVU, 32'hFFFFFFFF, 32'd0,          32'hFFFFFFFF,   1'b1);
    add(OP_REMU, 32'hDEADBEEF, 32'd0,          32'hDEADBEEF,   1'b1);
    add(OP_DIV,  32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1'b1);
    add(OP_REM,  32'h80000000, 32'hFFFFFFFF,   32'd0,          1'b1);
    add(OP_DIVU, 32'h80000000, 32'hFFFFFFFF,   32'd0,          1'b0);
    add(OP_REMU, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   1'b0);
    add(OP_DIVU, 32'd7,        32'd100,        32'd0,          1'b0);
    add(OP_REMU, 32'd7,        32'd100,        32'd7,          1'b0);
    add(OP_DIV,  32'h80000000, 32'd1,          32'h80000000,   1'b0);
    add(OP_DIV,  32'h80000000, 32'd2,          32'hC0000000,   1'b0);
    add(OP_REM,  32'h80000001, 32'd2,          32'hFFFFFFFF,   1'b0);
    add(OP_DIVU, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   1'b0);
    add(OP_DIVU, 32'd1000000,  32'd1000,       32'd1000,       1'b0);
    add(OP_DIVU, 32'hFFFFFFFF, 32'h10,         32'h0FFFFFFF,   1'b0);

    // Reset values
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_bit("reset/in_ready",  bus.in_ready,  1'b1);
    check_bit("reset/out_valid", bus.out_valid, 1'b0);
    check_bit("reset/busy",      bus.busy,      1'b0);
    check("reset/out", bus.out, 32'd0);
    tick();

    // Table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
             tbl[i].special ? LAT_SPECIAL : LAT_CALC, $sformatf("vec%0d", i));
    end

    // Back-pressure: result held, new requests ignored
    bus.out_ready = 1'b0;
    wait_ready("bp");
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
    exp_q.push_back(32'd14);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp/latency", 32'(lat), 32'(LAT_CALC));
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = $urandom; bus.b = $urandom;
      tick();
      check("bp/out_stable", bus.out, 32'd14);
      check_bit("bp/in_ready_low", bus.in_ready, 1'b0);
      check_bit("bp/valid_held", bus.out_valid, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_bit("bp/in_ready_back", bus.in_ready, 1'b1);
    check_bit("bp/valid_drop", bus.out_valid, 1'b0);
    tick();
    check_bit("bp/no_restart", bus.busy, 1'b0);

    // Flush mid-CALC at T+10
    wait_ready("flush");
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'h12345678; bus.b = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_bit("flush/in_ready", bus.in_ready, 1'b1);
    check_bit("flush/busy", bus.busy, 1'b0);
    check_bit("flush/out_valid", bus.out_valid, 1'b0);
    watch_no_valid("flush", 40);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, LAT_CALC, "post_flush");

    // Flush coincident with the handshake
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = OP_DIV; bus.a = 32'd5; bus.b = 32'd0;
    tick();
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check_bit("flush_hs/busy", bus.busy, 1'b0);
    watch_no_valid("flush_hs", 40);

    // Asynchronous reset mid-CALC, checked before the next rising edge
    wait_ready("areset");
    bus.in_valid = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.in_valid = 1'b0;
    repeat (19) tick();
    check_bit("areset/busy_before", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("areset/busy", bus.busy, 1'b0);
    check_bit("areset/in_ready", bus.in_ready, 1'b1);
    check_bit("areset/out_valid", bus.out_valid, 1'b0);
    check("areset/out", bus.out, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    watch_no_valid("areset", 40);

    // Unit still operational afterwards
    run_op(OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, LAT_CALC, "post_reset");

    check("sb/drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider implementing the RV32M DIV/DIVU/REM/REMU operations for the core's execute stage. It is the sequential counterpart to the single-cycle ALU. Execute hands it operands over a valid/ready handshake. The unit produces one quotient bit per cycle and holds the result until writeback accepts it. All RISC-V corner cases (divide-by-zero, signed overflow) resolve architecturally without traps.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; only 32 is supported, and the iteration count equals `XLEN`.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: execute presents an operation.
- `in_ready`, output, 1: unit can accept an operation; high only in IDLE.
- `op`, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `a`, input, 32: dividend (rs1).
- `b`, input, 32: divisor (rs2).
- `flush`, input, 1: abandon the current operation (pipeline redirect).
- `out_valid`, output, 1: `out` holds a finished result.
- `out_ready`, input, 1: writeback consumes the result.
- `out`, output, 32: quotient or remainder.
- `busy`, output, 1: high in CALC or DONE; used by the hazard unit to stall.

## Operation
- States: IDLE, CALC, DONE.
- IDLE -> CALC on `in_valid && in_ready`.
  - `op`, `a` and `b` are captured at this edge; later input changes are ignored.
  - Signed ops latch |a| and |b|, plus sign flags `neg_q = a[31]^b[31]` and `neg_r = a[31]`.
  - Unsigned ops latch raw values with both flags cleared.
- CALC: restoring division, MSB first, 6-bit iteration counter 0..31.
  - Each cycle: 33-bit trial `{rem[31:0], dvd[31]} - {1'b0, div}`.
  - If non-negative, the remainder takes the difference and quotient bit = 1; otherwise quotient bit = 0.
  - The dividend register shifts left one bit each cycle.
- CALC -> DONE after iteration 31. On that transition the final `out` is registered:
  - Quotient/remainder select comes from `op[1]`.
  - The quotient is negated if `neg_q`; the remainder is negated if `neg_r`.
  - Special cases below override this.
- DONE -> IDLE on `out_valid && out_ready`. `out` is held stable while `out_ready` is low.
- Required results:
  - Divide by zero: quotient = 0xFFFFFFFF (signed and unsigned); remainder = `a`.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Otherwise: quotient truncates toward zero; remainder takes the sign of the dividend.
- `flush` has priority in every state: the next state is IDLE, `out_valid` drops, and the result is discarded. A `flush` coincident with an input handshake discards that operation.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `out` = 0, state IDLE, counter 0.
- Handshake at edge T. CALC occupies cycles T+1..T+32. `out_valid` rises at T+33.
- With `out_ready` held high, the result retires at T+33 and `in_ready` returns at T+34. Throughput is one operation per 34 cycles.
- No input/output overlap: `in_ready` = 0 throughout CALC and DONE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- An asynchronous reset mid-CALC or mid-DONE clears state immediately. No result is produced.

## Configuration
- `DIV_EARLY_OUT_EN`
  - Defined: divide-by-zero and signed overflow are detected at capture, and IDLE goes directly to DONE. `out_valid` then rises at T+1.
  - Undefined: these cases run the full 32 iterations, with `out_valid` at T+33.
  - Result values are identical in both builds; only latency differs.

## Test plan
- DIVU a=100, b=7 with `out_ready`=1 -> `out`=14, `out_valid` at T+33. Repeat as REMU -> 2.
- DIV a=0xFFFFFF9C (-100), b=7 -> 0xFFFFFFF2 (-14). REM with the same operands -> 0xFFFFFFFE (-2).
- DIV a=5, b=0 -> 0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0. Latency must be T+1 with `DIV_EARLY_OUT_EN` and T+33 without.
- Hold `out_ready`=0 for 10 cycles after `out_valid`. `out` stays stable, `in_ready` stays 0, and a new `in_valid` is ignored. Retire, then `in_ready`=1 on the next cycle.
- Assert `flush` at T+10 mid-CALC -> IDLE next cycle, no `out_valid`. A following DIVU 0xFFFFFFFF / 0x10 yields 0x0FFFFFFF.
- Drop `rst_n` at T+20 -> `busy`=0, `in_ready`=1, `out_valid`=0 immediately, before the next clock edge.
